// File: rtl/sha3_state_gather_48.sv
// sha3_state_gather_48
// Collects WORDS beats of WIDTH bits into one registered state vector.
// Beat 0 is marked by isample_first; a completed state is held on ovector
// with ovalid until the consumer takes it with oready. Framing errors
// (unframed beats and restarts mid-state) bump a saturating counter.
module sha3_state_gather_48 #(
  parameter int WIDTH = 48,
  parameter int WORDS = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] isample,
  input  logic             isample_valid,
  input  logic             isample_first,
  output logic             isample_ready,
  output logic [WIDTH-1:0] ovector [WORDS],
  output logic             ovalid,
  input  logic             oready,
  output logic [7:0]       resync_count
);

  // Index width; WORDS >= 2 keeps this at least one bit.
  localparam int CW = (WORDS > 2) ? $clog2(WORDS) : 1;

  localparam logic [CW-1:0] IDX_LAST = CW'(WORDS - 1);
  localparam logic [CW-1:0] IDX_ZERO = '0;
  localparam logic [CW-1:0] IDX_ONE  = CW'(1);
  localparam logic [7:0]    RESYNC_MAX = 8'hFF;

  // COLLECT: gathering beats, ovector not valid.
  // HOLD:    complete state presented, waiting for the consumer.
  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [7:0]        resync_q, resync_d;
  logic [WIDTH-1:0]  vec_q [WORDS];
  logic [WIDTH-1:0]  vec_d [WORDS];

  logic              accept;
  logic              out_take;
  logic              wr_en;
  logic [CW-1:0]     wr_idx;
  logic              resync_inc;

  // A beat can enter whenever the held state is absent or leaving this cycle.
  assign ovalid        = (state_q == HOLD);
  assign isample_ready = !ovalid || oready;
  assign accept        = isample_valid && isample_ready;
  assign out_take      = ovalid && oready;
  assign resync_count  = resync_q;
  assign ovector       = vec_q;

  // Next-state: framing decisions for the accepted beat and HOLD release.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wr_en      = 1'b0;
    wr_idx     = IDX_ZERO;
    resync_inc = 1'b0;

    // The consumer has sampled the held state; it may be overwritten now.
    if (out_take) begin
      state_d = COLLECT;
    end

    if (accept) begin
      if (isample_first) begin
        // Start of a state; a non-zero index means the previous one was cut short.
        wr_en   = 1'b1;
        wr_idx  = IDX_ZERO;
        count_d = IDX_ONE;
        if (count_q != IDX_ZERO) begin
          resync_inc = 1'b1;
        end
      end else if (count_q == IDX_ZERO) begin
        // Beat with no frame start in front of it: drop it.
        resync_inc = 1'b1;
      end else begin
        wr_en  = 1'b1;
        wr_idx = count_q;
        if (count_q == IDX_LAST) begin
          count_d = IDX_ZERO;
          state_d = HOLD;
        end else begin
          count_d = count_q + IDX_ONE;
        end
      end
    end
  end

  // Saturating framing-error counter.
  always_comb begin
    resync_d = resync_q;
    if (resync_inc && (resync_q != RESYNC_MAX)) begin
      resync_d = resync_q + 8'd1;
    end
  end

  // Word write: only the addressed word changes, the rest keep their contents.
  always_comb begin
    for (int i = 0; i < WORDS; i++) begin
      vec_d[i] = vec_q[i];
      if (wr_en && (wr_idx == CW'(i))) begin
        vec_d[i] = isample;
      end
    end
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= COLLECT;
      count_q  <= IDX_ZERO;
      resync_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      resync_q <= resync_d;
    end
  end

  // State vector registers; cleared on reset so nothing stale leaks out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) begin
        vec_q[i] <= '0;
      end
    end else begin
      vec_q <= vec_d;
    end
  end

endmodule

// File: doc/sha3_state_gather_48.md
# sha3_state_gather_48

Serial-to-parallel collector that assembles one full Keccak state from a stream of 48-bit beats and presents it as a 34-word vector, ready for the 48-to-lane merge stage. It sits directly upstream of that merge stage: its `ovector` output drives the merge stage's `ivector` input one-to-one. It provides framing via a start-of-state flag, valid/ready backpressure on both sides, and a resync counter for diagnostics.

## Interface

Parameters:
- `WIDTH`, default 48: beat width in bits.
- `WORDS`, default 34: beats per state; must be ≥ 2.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `isample`, input, `WIDTH`: beat data.
- `isample_valid`, input, 1: beat present.
- `isample_first`, input, 1: beat is word 0 of a state; qualified by `isample_valid`.
- `isample_ready`, output, 1: block accepts a beat this cycle.
- `ovector`, output, `WIDTH` × `WORDS` (unpacked `[WORDS]`): assembled state. Word 0 is the first beat.
- `ovalid`, output, 1: `ovector` holds a complete state.
- `oready`, input, 1: consumer takes the state this cycle.
- `resync_count`, output, 8: number of framing errors, saturating at 255.

## Operation

- Accept condition: `isample_valid && isample_ready`.
- Handshake rules:
  - `isample_ready = !ovalid || oready` (combinational).
  - Output handshake: `ovalid && oready`.
- Two states:
  - **COLLECT** (`ovalid` = 0).
  - **HOLD** (`ovalid` = 1).
- Write index `count` ranges 0..`WORDS`-1.
- On an accepted beat:
  - `first` = 1: write `ovector[0]`, set `count` = 1. If `count` was ≠ 0 beforehand (restart mid-state), increment `resync_count` once.
  - `first` = 0 and `count` = 0: discard the beat and increment `resync_count`.
  - `first` = 0 and 0 < `count` < `WORDS`-1: write `ovector[count]` and increment `count`.
  - `first` = 0 and `count` = `WORDS`-1: write the last word, set `count` = 0, and set `ovalid` = 1 (enter HOLD).
  - `first` = 1 at `count` = `WORDS`-1 is a restart, not a completion.
- In HOLD:
  - `ovector` is stable until the output handshake.
  - On the handshake with no accepted beat: `ovalid` falls and the state is COLLECT.
  - On the handshake with an accepted beat in the same cycle: that beat is processed per the rules above (normally `first` = 1, written to word 0) and `ovalid` falls at the same edge. The consumer sampled the old contents, so this is legal.
  - With `ovalid` = 1 and `oready` = 0, `isample_ready` = 0 and no beats are accepted.
- `resync_count` holds at 255 once saturated.
- Words not rewritten keep their previous values. A partial state after a restart never asserts `ovalid`.

## Timing

- Reset values:
  - `ovalid` = 0.
  - `count` = 0.
  - `resync_count` = 0.
  - All `ovector` words = 0.
  - `isample_ready` = 1 (follows from `ovalid` = 0).
- Reset asserted mid-collection or in HOLD:
  - The partial or held state is abandoned immediately (asynchronous).
  - The first accepted beat after release needs `first` = 1.
- Latency: the last beat accepted at edge N makes `ovalid` high in the cycle after edge N. `ovector` is registered, with no combinational path from `isample`.
- Throughput: with `oready` held at 1 and `isample_valid` held at 1, one state is produced every `WORDS` cycles with no bubbles. HOLD overlaps with beat 0 of the next state.
- `isample_ready` depends combinationally on `oready`. `ovalid` and `ovector` depend only on registers.

## Test plan

- **Basic gather:** reset, then 34 beats with values 0..33 (`first` on beat 0) and `oready` = 1. Expected: `ovalid` pulses one cycle, 1 cycle after beat 33, with `ovector[k]` = k; `resync_count` = 0.
- **Back-to-back:** 3 states streamed continuously, with word k of state s = s·100+k. Expected: `ovalid` every 34 cycles, each vector correct, `isample_ready` never low.
- **Backpressure:** `oready` = 0 for 10 cycles after completion while the next state's beats are offered. Expected: `isample_ready` = 0 and `ovector` unchanged for those 10 cycles; the next beat is accepted on the cycle `oready` rises, and the second state is assembled correctly.
- **Mid-state restart:** 20 beats, then a new `first` beat followed by 33 beats of 0xAAAA_0000_0000+k. Expected: `resync_count` = 1, a single `ovalid`, and `ovector` holding only the second state.
- **Unframed beats and saturation:**
  - 5 beats with `first` = 0 after reset. Expected: all discarded, `resync_count` = 5, no `ovalid`.
  - 300 such beats. Expected: `resync_count` = 255.
- **Async reset in HOLD:** assert `rst` while `ovalid` = 1. Expected: `ovalid` = 0 and `ovector` = 0 immediately; a full state afterwards gathers correctly.
